sort_sequencer: RTL and testbench

//  Host-side job sequencer for the selection-sort core (sorting_top).
//  - Streams one block of 2**L words into sorter memory over a valid/ready port.
//  - Pulses start, then waits for done.
//  - Streams the words back in address order (0..2**L-1) over a valid/ready output port.

---
 rtl/sort_sequencer_if.sv | 34 +++
 rtl/sort_sequencer.sv | 114 +++++++++++
 tb/tb_sort_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_sequencer_if.sv
// Stream-in, stream-out and sorter-pin bundle for the sort sequencer.
interface sort_sequencer_if #(
  parameter int unsigned N = 8,
  parameter int unsigned L = 4
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_last;
  logic         out_ready;
  logic         busy;
  logic         s_wrinit;
  logic         s_rd;
  logic [L-1:0] s_raddr;
  logic [N-1:0] s_datain;
  logic         s_start;
  logic [N-1:0] s_dataout;
  logic         s_done;

  // Sequencer side: drives the sorter pins and both stream responses.
  modport master (
    input  in_valid, in_data, out_ready, s_dataout, s_done,
    output in_ready, out_valid, out_data, out_last, busy,
    output s_wrinit, s_rd, s_raddr, s_datain, s_start
  );

  modport slave (
    output in_valid, in_data, out_ready, s_dataout, s_done,
    input  in_ready, out_valid, out_data, out_last, busy,
    input  s_wrinit, s_rd, s_raddr, s_datain, s_start
  );
endinterface

// File: rtl/sort_sequencer.sv
// Host-side job sequencer: loads a 2**L word block into the sorter, starts it,
// waits for done, then streams the sorted block out through a 2-entry FIFO.
module sort_sequencer #(
  parameter int unsigned N = 8,
  parameter int unsigned L = 4
) (
  input logic              clk,
  input logic              rst,
  sort_sequencer_if.master bus
);

  typedef enum logic [1:0] {StLoad, StStart, StSort, StUnload} state_e;

  state_e       state_q;
  logic [L-1:0] addr_q;
  logic         sort_first_q;
  logic [L:0]   rd_cnt_q;
  logic         rd_pend_q;
  logic         rd_last_q;
  logic [N-1:0] fifo_data_q [2];
  logic [1:0]   fifo_last_q;
  logic [1:0]   fifo_cnt_q;
  logic         wptr_q;
  logic         rptr_q;

  logic       accept;
  logic       pop;
  logic       issue;
  logic       pop_last;
  logic [1:0] credit;

  always_comb begin
    accept   = (state_q == StLoad) && bus.in_valid;
    pop      = (fifo_cnt_q != 2'd0) && bus.out_ready;
    pop_last = pop && fifo_last_q[rptr_q];
    // Credit covers buffered words plus the read whose data lands next cycle.
    credit   = fifo_cnt_q + {1'b0, rd_pend_q};
    issue    = (state_q == StUnload) && !rd_cnt_q[L] && ((credit != 2'd2) || pop);
  end

  assign bus.in_ready  = (state_q == StLoad);
  assign bus.busy      = !((state_q == StLoad) && (addr_q == '0));
  assign bus.s_wrinit  = accept;
  assign bus.s_rd      = issue;
  assign bus.s_start   = (state_q == StStart);
  assign bus.s_raddr   = accept ? addr_q : (issue ? rd_cnt_q[L-1:0] : '0);
  assign bus.s_datain  = accept ? bus.in_data : '0;
  assign bus.out_valid = (fifo_cnt_q != 2'd0);
  assign bus.out_data  = fifo_data_q[rptr_q];
  assign bus.out_last  = bus.out_valid && fifo_last_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StLoad;
      addr_q         <= '0;
      sort_first_q   <= 1'b0;
      rd_cnt_q       <= '0;
      rd_pend_q      <= 1'b0;
      rd_last_q      <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      fifo_cnt_q     <= '0;
      wptr_q         <= 1'b0;
      rptr_q         <= 1'b0;
    end else begin
      if (issue) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
      rd_pend_q <= issue;
      rd_last_q <= (rd_cnt_q[L-1:0] == {L{1'b1}});

      if (rd_pend_q) begin
        fifo_data_q[wptr_q] <= bus.s_dataout;
        fifo_last_q[wptr_q] <= rd_last_q;
        wptr_q              <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};

      unique case (state_q)
        StLoad: begin
          if (accept) begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == {L{1'b1}}) begin
              state_q <= StStart;
            end
          end
        end
        StStart: begin
          state_q      <= StSort;
          sort_first_q <= 1'b1;
        end
        StSort: begin
          // done may still be high from the previous job during the first cycle
          sort_first_q <= 1'b0;
          if (!sort_first_q && bus.s_done) begin
            state_q <= StUnload;
          end
        end
        StUnload: begin
          if (pop_last) begin
            state_q  <= StLoad;
            rd_cnt_q <= '0;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Randomised scoreboard bench for sort_sequencer with a behavioural sorter model.
module tb_sort_sequencer;
  localparam int N = 8;
  localparam int L = 4;
  localparam int BLK = 16;

  typedef logic [7:0] blk_t [16];

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   mode;  // 1: out_ready held high, 0: random

  sort_sequencer_if #(.N(N), .L(L)) bus ();

  sort_sequencer #(.N(N), .L(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Sorter model: done stays stale for one cycle after start, then drops; the
  // memory only becomes sorted when done rises again.
  blk_t       smem = '{default: 8'h00};
  logic [7:0] m_dout = 8'h00;
  logic       m_done = 1'b1;
  bit         start_seen = 1'b0;
  int         sort_timer = 0;

  assign bus.s_dataout = m_dout;
  assign bus.s_done    = m_done;

  function automatic blk_t sort_blk(input blk_t a);
    blk_t r = a;
    logic [7:0] t;
    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < 15 - i; j++) begin
        if (r[j] > r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.s_wrinit) smem[bus.s_raddr] <= bus.s_datain;
    if (bus.s_rd) m_dout <= smem[bus.s_raddr];
    start_seen <= bus.s_start;
    if (start_seen) begin
      m_done     <= 1'b0;
      sort_timer <= $urandom_range(2, 8);
    end else if (sort_timer > 1) begin
      sort_timer <= sort_timer - 1;
    end else if (sort_timer == 1) begin
      smem       <= sort_blk(smem);
      m_done     <= 1'b1;
      sort_timer <= 0;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard state
  logic [7:0] cur_job [$];
  logic [7:0] exp_d [$];
  bit         exp_last [$];
  int         wr_cnt, rd_cnt, pop_cnt, cycle, first_rd;
  bit         in_job, start_due, prev_stall, stall_seen;
  logic [7:0] prev_data;
  logic       prev_last;

  initial begin
    logic [7:0] srt [$];
    wr_cnt = 0; rd_cnt = 0; pop_cnt = 0; cycle = 0; first_rd = 0;
    in_job = 0; start_due = 0; prev_stall = 0; stall_seen = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        cur_job.delete(); exp_d.delete(); exp_last.delete();
        wr_cnt = 0; rd_cnt = 0; pop_cnt = 0;
        in_job = 0; start_due = 0; prev_stall = 0; stall_seen = 0;
        continue;
      end
      check("in_ready", bus.in_ready, !in_job);
      check("busy", bus.busy, in_job || (wr_cnt != 0));
      check("s_start", bus.s_start, start_due);
      start_due = 0;
      check("s_wrinit", bus.s_wrinit, bus.in_valid && bus.in_ready);
      if (bus.s_wrinit || bus.s_rd || bus.s_start)
        check("excl", int'(bus.s_wrinit) + int'(bus.s_rd) + int'(bus.s_start), 1);
      if (in_job && !bus.out_ready) stall_seen = 1;

      if (bus.in_valid && bus.in_ready) begin
        check("wr_addr", bus.s_raddr, wr_cnt);
        check("wr_data", bus.s_datain, bus.in_data);
        cur_job.push_back(bus.in_data);
        wr_cnt++;
        if (wr_cnt == BLK) begin
          srt = cur_job;
          srt.sort();
          for (int i = 0; i < BLK; i++) begin
            exp_d.push_back(srt[i]);
            exp_last.push_back(i == BLK - 1);
          end
          cur_job.delete();
          wr_cnt = 0; in_job = 1; start_due = 1;
        end
      end

      if (bus.s_rd) begin
        check("rd_addr", bus.s_raddr, rd_cnt);
        if (rd_cnt == 0) first_rd = cycle;
        rd_cnt++;
      end

      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev_data);
        check("stall_last", bus.out_last, prev_last);
      end

      if (bus.out_valid && bus.out_ready) begin
        if (exp_d.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          check("out_data", bus.out_data, exp_d.pop_front());
          check("out_last", bus.out_last, exp_last.pop_front());
          pop_cnt++;
        end
      end
      if (bus.s_rd || (bus.out_valid && bus.out_ready))
        check("credit", (rd_cnt - pop_cnt) <= 2, 1);
      if (pop_cnt == BLK) begin
        if (!stall_seen) check("throughput", cycle - first_rd, 17);
        check("reads", rd_cnt, BLK);
        in_job = 0; rd_cnt = 0; pop_cnt = 0; stall_seen = 0;
      end

      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = mode ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send_word(input logic [7:0] d);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("load_timeout", 0, 1);
  endtask

  task automatic gap();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      ok = !in_job && (exp_d.size() == 0) && (wr_cnt == 0);
    end
    check("drain", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_s_wrinit", bus.s_wrinit, 0);
    check("rst_s_rd", bus.s_rd, 0);
    check("rst_s_start", bus.s_start, 0);
    check("rst_s_raddr", bus.s_raddr, 0);
  endtask

  task automatic do_reset(input int n);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] job1 [16] = '{9, 3, 15, 0, 7, 12, 1, 14, 5, 10, 2, 13, 6, 11, 4, 8};
    bit ok;
    rst = 1'b1;
    mode = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Known permutation with a gap every third cycle, sink always ready.
    for (int i = 0; i < BLK; i++) begin
      send_word(job1[i]);
      if (i % 2 == 1) gap();
    end
    bus.in_valid = 1'b0;
    wait_drain();

    // Random data, random gaps, random backpressure.
    mode = 1'b0;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < BLK; i++) begin
        send_word(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 2) == 0) gap();
      end
      bus.in_valid = 1'b0;
      wait_drain();
    end

    // Abort a job partway through unloading.
    for (int i = 0; i < BLK; i++) send_word(8'($urandom_range(0, 255)));
    bus.in_valid = 1'b0;
    ok = 0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      ok = (pop_cnt >= 5);
    end
    check("unload_reached", ok, 1);
    @(posedge clk);
    #1;
    do_reset(3);
    repeat (4) begin
      @(negedge clk);
      check("post_rst_out_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Three jobs back-to-back with in_valid held high throughout.
    for (int i = 0; i < 3 * BLK; i++) send_word(8'($urandom_range(0, 255)));
    bus.in_valid = 1'b0;
    wait_drain();

    // One more fully-streaming job after the random phases.
    mode = 1'b1;
    for (int i = 0; i < BLK; i++) send_word(8'($urandom_range(0, 255)));
    bus.in_valid = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
